// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the lc3b memory port between instruction fetch (I)
// and load/store (D). Define MEM_ARBITER_RR_EN for round-robin on contention.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  // port I: instruction fetch
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [DATA_W-1:0] i_rdata,
  // port D: load/store
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_byte_enable,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  // physical memory
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant_d, last_grant_d_next;  // 0 = I served last, 1 = D
  logic   d_req;

  assign d_req = d_read | d_write;

  // Read data is a plain mirror; only the resp pulse qualifies it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // NOTE: state registers use non-blocking assignments and an async reset so
  // every decoded output falls to its idle value the moment reset_n drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
    end else begin
      state        <= state_next;
      last_grant_d <= last_grant_d_next;
    end
  end

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next        = state;
    last_grant_d_next = last_grant_d;
    grant             = 2'b00;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_address       = '0;
    mem_wdata         = '0;
    mem_byte_enable   = '0;
    i_resp            = 1'b0;
    d_resp            = 1'b0;

    unique case (state)
      IDLE: begin
`ifdef MEM_ARBITER_RR_EN
        if (d_req && i_read)
          state_next = last_grant_d ? GRANT_I : GRANT_D;
        else if (d_req)
          state_next = GRANT_D;
        else if (i_read)
          state_next = GRANT_I;
`else
        if (d_req)
          state_next = GRANT_D;
        else if (i_read)
          state_next = GRANT_I;
`endif
      end

      GRANT_I: begin
        grant           = 2'b01;
        mem_read        = i_read;
        mem_address     = i_address;
        mem_byte_enable = '1;
        i_resp          = mem_resp;
        if (mem_resp) begin
          state_next        = IDLE;
          last_grant_d_next = 1'b0;
        end else if (!i_read) begin
          state_next = IDLE;
        end
      end

      GRANT_D: begin
        grant           = 2'b10;
        mem_write       = d_write;
        mem_read        = d_read & ~d_write;  // a simultaneous write wins
        mem_address     = d_address;
        mem_wdata       = d_wdata;
        mem_byte_enable = d_write ? d_byte_enable : '1;
        d_resp          = mem_resp;
        if (mem_resp) begin
          state_next        = IDLE;
          last_grant_d_next = 1'b1;
        end else if (!d_req) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a transaction-level ownership model is
// compared against the DUT every cycle, alongside hand-computed literal checks.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read = 1'b0, d_write = 1'b0;
  logic [15:0] d_address = '0, d_wdata = '0;
  logic [1:0]  d_byte_enable = '0;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory port (0 none, 1 I, 2 D) and who was served last.
  int owner = 0;
  bit last_was_d = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= 0;
      last_was_d <= 1'b0;
    end else if (owner == 0) begin
      if ((d_read || d_write) && i_read)
        owner <= (RR && last_was_d) ? 1 : 2;
      else if (d_read || d_write)
        owner <= 2;
      else if (i_read)
        owner <= 1;
    end else if (mem_resp) begin
      last_was_d <= (owner == 2);
      owner      <= 0;
    end else if ((owner == 1 && !i_read) || (owner == 2 && !d_read && !d_write)) begin
      owner <= 0;
    end
  end

  // Per-cycle comparison of all outputs against what the owner implies.
  logic [1:0]  e_grant, e_be;
  logic        e_rd, e_wr, e_iresp, e_dresp;
  logic [15:0] e_addr, e_wdata;
  always @(negedge clk) begin
    e_grant = 2'b00; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    e_be = 2'b00; e_iresp = 1'b0; e_dresp = 1'b0;
    if (owner == 1) begin
      e_grant = 2'b01; e_rd = i_read; e_addr = i_address; e_be = 2'b11;
      e_iresp = mem_resp;
    end else if (owner == 2) begin
      e_grant = 2'b10; e_wr = d_write; e_rd = d_read && !d_write;
      e_addr = d_address; e_wdata = d_wdata;
      e_be = d_write ? d_byte_enable : 2'b11; e_dresp = mem_resp;
    end
    check("m_grant", grant, e_grant);
    check("m_mem_read", mem_read, e_rd);
    check("m_mem_write", mem_write, e_wr);
    check("m_mem_address", mem_address, e_addr);
    if (owner != 1) check("m_mem_wdata", mem_wdata, e_wdata);
    check("m_mem_byte_enable", mem_byte_enable, e_be);
    check("m_i_resp", i_resp, e_iresp);
    check("m_d_resp", d_resp, e_dresp);
    check("m_i_rdata", i_rdata, mem_rdata);
    check("m_d_rdata", d_rdata, mem_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_mem_read", mem_read, 1'b0);

    // Single instruction fetch.
    step(); i_read = 1'b1; i_address = 16'h0040;
    @(negedge clk); check("i_arb_cycle_read", mem_read, 1'b0);
    step(); @(negedge clk);
    check("i_grant", grant, 2'b01);
    check("i_mem_read", mem_read, 1'b1);
    check("i_mem_address", mem_address, 16'h0040);
    check("i_mem_be", mem_byte_enable, 2'b11);
    step(); step(); step(); mem_resp = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    check("i_resp", i_resp, 1'b1);
    check("i_rdata", i_rdata, 16'h1234);
    step(); clear_all();
    @(negedge clk);
    check("i_resp_pulse", i_resp, 1'b0);
    check("i_back_idle", grant, 2'b00);

    // Data write with byte mask, then read+write overlap.
    step(); d_write = 1'b1; d_address = 16'h0100; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
    step(); @(negedge clk);
    check("d_grant", grant, 2'b10);
    check("d_mem_write", mem_write, 1'b1);
    check("d_mem_read", mem_read, 1'b0);
    check("d_mem_address", mem_address, 16'h0100);
    check("d_mem_wdata", mem_wdata, 16'hBEEF);
    check("d_mem_be", mem_byte_enable, 2'b01);
    step(); d_read = 1'b1;
    @(negedge clk);
    check("d_rw_read_low", mem_read, 1'b0);
    check("d_rw_write_high", mem_write, 1'b1);
    step(); mem_resp = 1'b1;
    @(negedge clk); check("d_resp", d_resp, 1'b1);
    step(); clear_all();

    // Contention: fixed priority serves D first; round-robin (last = D) serves I.
    step(); i_read = 1'b1; i_address = 16'h0200; d_read = 1'b1; d_address = 16'h0300;
    d_byte_enable = 2'b00;
    step(); @(negedge clk);
    check("ct_first_grant", grant, RR ? 2'b01 : 2'b10);
    check("ct_first_addr", mem_address, RR ? 16'h0200 : 16'h0300);
    step(); mem_resp = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    check("ct_first_resp", {i_resp, d_resp}, RR ? 2'b10 : 2'b01);
    step(); mem_resp = 1'b0;
    if (RR) i_read = 1'b0; else d_read = 1'b0;
    @(negedge clk); check("ct_idle_gap", grant, 2'b00);
    step(); @(negedge clk);
    check("ct_second_grant", grant, RR ? 2'b10 : 2'b01);
    step(); mem_resp = 1'b1; mem_rdata = 16'h6666;
    @(negedge clk);
    check("ct_second_resp", {i_resp, d_resp}, RR ? 2'b01 : 2'b10);
    step(); clear_all();

    // Stray mem_resp in IDLE.
    step(); mem_resp = 1'b1;
    @(negedge clk);
    check("stray_resp", {i_resp, d_resp}, 2'b00);
    step(); @(negedge clk);
    check("stray_idle", grant, 2'b00);
    step(); mem_resp = 1'b0;

    // Asynchronous reset two cycles into GRANT_D, write request held.
    step(); d_write = 1'b1; d_address = 16'h0400; d_wdata = 16'h1111; d_byte_enable = 2'b11;
    step(); @(negedge clk); check("rs_grant_d", grant, 2'b10);
    step(); @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rs_async_write", mem_write, 1'b0);
    check("rs_async_grant", grant, 2'b00);
    check("rs_no_resp", d_resp, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk); check("rs_idle_after", grant, 2'b00);
    step(); @(negedge clk);
    check("rs_regrant", grant, 2'b10);
    check("rs_regrant_write", mem_write, 1'b1);
    step(); mem_resp = 1'b1;
    @(negedge clk); check("rs_resp", d_resp, 1'b1);
    step(); clear_all();

    // Abort: D drops its read before mem_resp.
    step(); d_read = 1'b1; d_address = 16'h0500;
    step(); @(negedge clk);
    check("ab_mem_read", mem_read, 1'b1);
    #1 d_read = 1'b0;
    #1;
    check("ab_read_drop", mem_read, 1'b0);
    step(); @(negedge clk);
    check("ab_idle", grant, 2'b00);
    check("ab_no_resp", d_resp, 1'b0);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
